alu_seq8: RTL and testbench

ALU_SEQ8 -- requirements
Module: alu_seq8

---
 rtl/alu_seq8.sv | 151 +++++++++++++++
 tb/tb_alu_seq8.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq8.sv
// alu_seq8: 8-bit sequential ALU front end built around an external 4-bit
// combinational ALU. Each command is processed as a low nibble then a high
// nibble, with the add carry chained from the low pass into the high pass.
`timescale 1ns/1ps

module alu_seq8 #(
    parameter bit RSVD_ERR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    // command side
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    input  logic       cin,
    // external 4-bit ALU
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic       alu_sel0,
    output logic       alu_sel1,
    output logic       alu_sel2,
    input  logic [3:0] alu_out,
    input  logic       alu_cout,
    // result side
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Captured command; stays frozen from acceptance until the next accept.
    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } cmd_t;

    state_t     state, state_nxt;
    cmd_t       cmd_q;
    logic [3:0] res_lo_q;
    logic       lo_carry_q;
    logic       is_add;
    logic       is_rsvd;
    logic [7:0] res_full;

    assign is_add   = (cmd_q.op == 3'b000);
    assign is_rsvd  = cmd_q.op[2] & (cmd_q.op[1] | cmd_q.op[0]);
    // Full 8-bit result as it will be registered on the HI->DONE edge.
    assign res_full = {alu_out, res_lo_q};

    // State register; reset wins over every handshake.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: one pass per nibble, then hold in DONE until consumed.
    // Consumption returns to IDLE, so accept and consume never share an edge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid)  state_nxt = S_LO;
            S_LO:                  state_nxt = S_HI;
            S_HI:                  state_nxt = S_DONE;
            S_DONE: if (res_ready) state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Outputs: handshakes plus ALU drive; ALU inputs are quiet outside LO/HI.
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_cin   = 1'b0;
        alu_sel0  = 1'b0;
        alu_sel1  = 1'b0;
        alu_sel2  = 1'b0;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_LO: begin
                alu_a    = cmd_q.a[3:0];
                alu_b    = cmd_q.b[3:0];
                alu_cin  = is_add & cmd_q.cin;
                {alu_sel2, alu_sel1, alu_sel0} = cmd_q.op;
            end
            S_HI: begin
                alu_a    = cmd_q.a[7:4];
                alu_b    = cmd_q.b[7:4];
                alu_cin  = is_add & lo_carry_q;
                {alu_sel2, alu_sel1, alu_sel0} = cmd_q.op;
            end
            S_DONE: res_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture command in IDLE, low nibble in LO, publish in HI.
    // The visible result only changes on HI->DONE so it stays stable after
    // consumption until the next command completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            res_lo_q   <= 4'h0;
            lo_carry_q <= 1'b0;
            result     <= 8'h00;
            carry      <= 1'b0;
            zero       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cmd_q.op  <= op;
                        cmd_q.a   <= opa;
                        cmd_q.b   <= opb;
                        cmd_q.cin <= cin;
                    end
                end
                S_LO: begin
                    res_lo_q   <= alu_out;
                    lo_carry_q <= alu_cout;
                end
                S_HI: begin
                    result <= res_full;
                    carry  <= is_add & alu_cout;
                    zero   <= (res_full == 8'h00);
                    err    <= RSVD_ERR & is_rsvd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq8.sv
// tb_alu_seq8: directed + random stimulus, queue scoreboard, negedge monitor.
`timescale 1ns/1ps

module tb_alu_seq8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, res_ready, cin;
    logic [2:0] op;
    logic [7:0] opa, opb;

    // DUT with reserved-op flagging enabled
    logic       in_ready, alu_cin, alu_sel0, alu_sel1, alu_sel2, alu_cout;
    logic [3:0] alu_a, alu_b, alu_out;
    logic       res_valid, carry, zero, err;
    logic [7:0] result;

    // twin with flagging disabled, same stimulus
    logic       in_ready_1, alu_cin_1, alu_sel0_1, alu_sel1_1, alu_sel2_1, alu_cout_1;
    logic [3:0] alu_a_1, alu_b_1, alu_out_1;
    logic       res_valid_1, carry_1, zero_1, err_1;
    logic [7:0] result_1;

    // Behavioural 4-bit ALU attached to each DUT
    function automatic logic [4:0] alu4(input logic [2:0] s, input logic [3:0] a,
                                        input logic [3:0] b, input logic c);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b} + {4'b0, c};
            3'd1:    return {1'b0, a & b};
            3'd2:    return {1'b0, a | b};
            3'd3:    return {1'b0, ~(a & b)};
            3'd4:    return {1'b0, ~(a | b)};
            default: return 5'd0;
        endcase
    endfunction

    assign {alu_cout, alu_out}     = alu4({alu_sel2, alu_sel1, alu_sel0}, alu_a, alu_b, alu_cin);
    assign {alu_cout_1, alu_out_1} = alu4({alu_sel2_1, alu_sel1_1, alu_sel0_1}, alu_a_1, alu_b_1, alu_cin_1);

    alu_seq8 #(.RSVD_ERR(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .opa(opa), .opb(opb), .cin(cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_sel0(alu_sel0), .alu_sel1(alu_sel1), .alu_sel2(alu_sel2),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .carry(carry), .zero(zero), .err(err)
    );

    alu_seq8 #(.RSVD_ERR(1'b0)) dut_noerr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
        .op(op), .opa(opa), .opb(opb), .cin(cin),
        .alu_a(alu_a_1), .alu_b(alu_b_1), .alu_cin(alu_cin_1),
        .alu_sel0(alu_sel0_1), .alu_sel1(alu_sel1_1), .alu_sel2(alu_sel2_1),
        .alu_out(alu_out_1), .alu_cout(alu_cout_1),
        .res_valid(res_valid_1), .res_ready(res_ready),
        .result(result_1), .carry(carry_1), .zero(zero_1), .err(err_1)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b;
        logic       cin;
        logic       lo_c;   // carry out of the low-nibble add
        logic [7:0] res;
        logic       c, z, e;
        int         acc;    // edge number of the accepting edge
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   checks = 0, errors = 0;
    int   stall_left = 0;
    bit   rand_ready = 0;
    logic [7:0] last_res = 8'h00;
    logic       last_c = 0, last_z = 0, last_e = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference: whole 8-bit operation computed directly from the opcode table
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] a,
                                   input logic [7:0] b, input logic c);
        exp_t x;
        int   sum;
        x.op = o; x.a = a; x.b = b; x.cin = c; x.c = 0; x.acc = 0;
        x.lo_c = ((int'(a[3:0]) + int'(b[3:0]) + int'(c)) > 15);
        case (o)
            3'd0: begin
                sum   = int'(a) + int'(b) + int'(c);
                x.res = sum[7:0];
                x.c   = (sum > 255);
            end
            3'd1:    x.res = a & b;
            3'd2:    x.res = a | b;
            3'd3:    x.res = ~(a & b);
            3'd4:    x.res = ~(a | b);
            default: x.res = 8'h00;
        endcase
        x.z = (x.res == 8'h00);
        x.e = (o >= 3'd5);
        return x;
    endfunction

    // Consumer: random or full readiness, with an optional forced stall in DONE
    always @(posedge clk) begin
        #2;
        if (stall_left > 0) begin
            res_ready = 1'b0;
            if (res_valid) stall_left--;
        end else
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: phase of the outstanding command follows from its accept edge
    always @(negedge clk) begin
        int ph;
        ph = (q.size() > 0) ? (edge_cnt - q[0].acc) : -1;
        if (ph < 0) begin
            chk("idle_ctl", {res_valid, in_ready}, 2'b01);
            chk("idle_alu", {alu_a, alu_b, alu_cin, alu_sel2, alu_sel1, alu_sel0}, 12'h0);
            chk("idle_hold", {result, carry, zero, err}, {last_res, last_c, last_z, last_e});
        end else if (ph == 0) begin
            chk("lo_ctl", {res_valid, in_ready}, 2'b00);
            chk("lo_alu", {alu_a, alu_b, alu_cin, alu_sel2, alu_sel1, alu_sel0},
                {q[0].a[3:0], q[0].b[3:0], (q[0].op == 3'd0) & q[0].cin, q[0].op});
        end else if (ph == 1) begin
            chk("hi_ctl", {res_valid, in_ready}, 2'b00);
            chk("hi_alu", {alu_a, alu_b, alu_cin, alu_sel2, alu_sel1, alu_sel0},
                {q[0].a[7:4], q[0].b[7:4], (q[0].op == 3'd0) & q[0].lo_c, q[0].op});
        end else if (ph > 60) begin
            chk("done_timeout", ph, 60);
            void'(q.pop_front());
        end else begin
            // ph==2 is the first DONE cycle: three transitions incl. the accepting one
            chk("done_ctl", {res_valid, in_ready}, 2'b10);
            chk("done_alu", {alu_a, alu_b, alu_cin, alu_sel2, alu_sel1, alu_sel0}, 12'h0);
            chk("done_res", {result, carry, zero, err}, {q[0].res, q[0].c, q[0].z, q[0].e});
            chk("noerr_res", {res_valid_1, result_1, carry_1, zero_1, err_1},
                {1'b1, q[0].res, q[0].c, q[0].z, 1'b0});
            if (res_ready) begin
                last_res = q[0].res; last_c = q[0].c; last_z = q[0].z; last_e = q[0].e;
                void'(q.pop_front());
            end
        end
    end

    // Issue one command; noise on the input bus while the block is busy
    task automatic issue(input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
        exp_t x;
        int   n = 0;
        @(negedge clk);
        while (!in_ready) begin
            in_valid = 1'($urandom_range(0, 1));
            op  = 3'($urandom);
            opa = 8'($urandom);
            opb = 8'($urandom);
            cin = 1'($urandom);
            n++;
            if (n > 100) begin
                chk("issue_timeout", n, 100);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        op = o; opa = a; opb = b; cin = c; in_valid = 1'b1;
        x = model(o, a, b, c);
        x.acc = edge_cnt + 1;
        q.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Synchronous reset pulse launched just after a negedge
    task automatic pulse_reset();
        #1;
        rst = 1'b1; in_valid = 1'b0;
        q.delete();
        last_res = 8'h00; last_c = 0; last_z = 0; last_e = 0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
        op = 3'd0; opa = 8'h00; opb = 8'h00; cin = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        issue(3'd0, 8'h7F, 8'h01, 1'b0);   // ADD into sign bit
        issue(3'd0, 8'hFF, 8'h00, 1'b1);   // carry ripples through both nibbles
        issue(3'd3, 8'hF0, 8'hFF, 1'b1);   // NAND ignores cin
        issue(3'd6, 8'hAA, 8'h55, 1'b0);   // reserved opcode
        issue(3'd1, 8'h3C, 8'h5A, 1'b0);
        issue(3'd2, 8'h00, 8'h00, 1'b1);
        issue(3'd4, 8'h0F, 8'h30, 1'b0);
        stall_left = 5;                    // hold the next result for 5 cycles
        issue(3'd0, 8'h12, 8'h34, 1'b0);
        issue(3'd5, 8'h01, 8'h02, 1'b1);
        issue(3'd7, 8'hFF, 8'hFF, 1'b1);

        // abort an ADD while it is in HI
        issue(3'd0, 8'h55, 8'hAA, 1'b1);
        @(negedge clk);
        pulse_reset();
        issue(3'd0, 8'h0F, 8'hF1, 1'b0);

        rand_ready = 1;
        for (int i = 0; i < 300; i++)
            issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));

        rand_ready = 0;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
